// File: rtl/lcd_pkg.sv
// Shared types, HD44780 command constants and helpers for the character-LCD driver.
package lcd_pkg;

  typedef enum logic [2:0] {
    S_PWR_WAIT,
    S_INIT,
    S_IDLE,
    S_SET_ADDR,
    S_WRITE_CHAR
  } state_t;

  typedef enum logic [2:0] {
    N_IDLE,
    N_SETUP,
    N_HIGH,
    N_HOLD,
    N_GAP,
    N_WAIT
  } nib_state_t;

  localparam logic [7:0] CMD_FUNC_SET   = 8'h28;
  localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;
  localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_SET_DDRAM  = 8'h80;

  localparam int unsigned INIT_LEN = 8;

  typedef struct packed {
    logic [7:0] code;
    logic       single_nibble;
    logic       long_wait;
  } init_cmd_t;

  // Power-on sequence: four wake-up nibbles (8-bit mode x3, then 4-bit), then full bytes.
  function automatic init_cmd_t init_rom(input logic [2:0] idx);
    case (idx)
      3'd0:    return '{code: 8'h03,           single_nibble: 1'b1, long_wait: 1'b1};
      3'd1:    return '{code: 8'h03,           single_nibble: 1'b1, long_wait: 1'b0};
      3'd2:    return '{code: 8'h03,           single_nibble: 1'b1, long_wait: 1'b0};
      3'd3:    return '{code: 8'h02,           single_nibble: 1'b1, long_wait: 1'b0};
      3'd4:    return '{code: CMD_FUNC_SET,    single_nibble: 1'b0, long_wait: 1'b0};
      3'd5:    return '{code: CMD_ENTRY_MODE,  single_nibble: 1'b0, long_wait: 1'b0};
      3'd6:    return '{code: CMD_DISP_ON,     single_nibble: 1'b0, long_wait: 1'b0};
      default: return '{code: CMD_CLEAR,       single_nibble: 1'b0, long_wait: 1'b1};
    endcase
  endfunction

  // DDRAM start address of each display row.
  function automatic logic [7:0] row_base(input logic [1:0] row, input logic [7:0] cols);
    case (row)
      2'd0:    return 8'h00;
      2'd1:    return 8'h40;
      2'd2:    return cols;
      default: return 8'h40 + cols;
    endcase
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Sends one nibble or one byte over the 4-bit HD44780 bus with E timing and post-write wait.
module lcd_nibble_tx
  import lcd_pkg::*;
#(
  parameter int unsigned T_E   = 12,
  parameter int unsigned T_NIB = 50,
  parameter int unsigned T_CMD = 2000,
  parameter int unsigned T_CLR = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       rs,
  input  logic       single_nibble,
  input  logic       long_wait,
  output logic       done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [3:0] lcd_data
);

  localparam int unsigned CNT_MAX = max2(max2(T_CLR, T_CMD), max2(T_NIB, T_E));
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  nib_state_t       st;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       lo_nib;
  logic             last;
  logic             long_q;

  // Setup / E-high / hold phases per nibble; data and RS only move while E is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= N_IDLE;
      cnt      <= '0;
      lo_nib   <= '0;
      last     <= 1'b0;
      long_q   <= 1'b0;
      done     <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= '0;
    end else begin
      done <= 1'b0;
      case (st)
        N_IDLE: if (start) begin
          lcd_rs   <= rs;
          lcd_data <= single_nibble ? tx_byte[3:0] : tx_byte[7:4];
          lo_nib   <= tx_byte[3:0];
          last     <= single_nibble;
          long_q   <= long_wait;
          cnt      <= CNT_W'(T_E - 1);
          st       <= N_SETUP;
        end
        N_SETUP: if (cnt == '0) begin
          lcd_e <= 1'b1;
          cnt   <= CNT_W'(T_E - 1);
          st    <= N_HIGH;
        end else cnt <= cnt - CNT_W'(1);
        N_HIGH: if (cnt == '0) begin
          lcd_e <= 1'b0;
          cnt   <= CNT_W'(T_E - 1);
          st    <= N_HOLD;
        end else cnt <= cnt - CNT_W'(1);
        N_HOLD: if (cnt == '0) begin
          if (last) begin
            cnt <= long_q ? CNT_W'(T_CLR - 1) : CNT_W'(T_CMD - 1);
            st  <= N_WAIT;
          end else begin
            cnt <= CNT_W'(T_NIB - 1);
            st  <= N_GAP;
          end
        end else cnt <= cnt - CNT_W'(1);
        N_GAP: if (cnt == '0) begin
          lcd_data <= lo_nib;
          last     <= 1'b1;
          cnt      <= CNT_W'(T_E - 1);
          st       <= N_SETUP;
        end else cnt <= cnt - CNT_W'(1);
        N_WAIT: if (cnt == '0) begin
          done <= 1'b1;
          st   <= N_IDLE;
        end else cnt <= cnt - CNT_W'(1);
        default: st <= N_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lcd_text_driver.sv
// HD44780 4-bit write-only text driver: power-on init, then ROWS x COLS frames row by row.
module lcd_text_driver
  import lcd_pkg::*;
#(
  parameter int unsigned ROWS    = 2,
  parameter int unsigned COLS    = 16,
  parameter int unsigned T_PWRUP = 750000,
  parameter int unsigned T_E     = 12,
  parameter int unsigned T_NIB   = 50,
  parameter int unsigned T_CMD   = 2000,
  parameter int unsigned T_CLR   = 82000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ROWS*COLS*8-1:0] frame_data,
  input  logic                   frame_valid,
  output logic                   frame_ready,
  output logic                   busy,
  output logic                   lcd_rs,
  output logic                   lcd_w,
  output logic                   lcd_e,
  output logic [3:0]             lcd_data
);

  localparam int unsigned FRAME_W = ROWS * COLS * 8;
  localparam int unsigned ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned COL_W   = $clog2(COLS);
  localparam int unsigned WAIT_W  = $clog2(max2(T_PWRUP, T_CLR) + 1);

  state_t             state;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [2:0]         init_idx;
  logic [ROW_W-1:0]   row;
  logic [COL_W-1:0]   col;
  logic [FRAME_W-1:0] frame_reg;
  logic               pending;
  logic               start;
  logic [7:0]         tx_byte;
  logic               tx_rs;
  logic               tx_single;
  logic               tx_long;
  logic               tx_done;
  init_cmd_t          rom_cmd;

  assign rom_cmd = init_rom(init_idx);
  assign lcd_w   = 1'b0;

  // Each busy state issues one transfer, then waits for the engine's done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_PWR_WAIT;
      wait_cnt    <= '0;
      init_idx    <= '0;
      row         <= '0;
      col         <= '0;
      frame_reg   <= '0;
      pending     <= 1'b0;
      start       <= 1'b0;
      tx_byte     <= '0;
      tx_rs       <= 1'b0;
      tx_single   <= 1'b0;
      tx_long     <= 1'b0;
      frame_ready <= 1'b0;
      busy        <= 1'b1;
    end else begin
      start <= 1'b0;
      case (state)
        S_PWR_WAIT: begin
          if (wait_cnt == WAIT_W'(T_PWRUP - 1)) begin
            wait_cnt <= '0;
            state    <= S_INIT;
          end else wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        S_INIT: begin
          if (!pending) begin
            start     <= 1'b1;
            pending   <= 1'b1;
            tx_byte   <= rom_cmd.code;
            tx_rs     <= 1'b0;
            tx_single <= rom_cmd.single_nibble;
            tx_long   <= rom_cmd.long_wait;
          end else if (tx_done) begin
            pending <= 1'b0;
            if (init_idx == 3'(INIT_LEN - 1)) begin
              state       <= S_IDLE;
              frame_ready <= 1'b1;
              busy        <= 1'b0;
            end else init_idx <= init_idx + 3'd1;
          end
        end
        S_IDLE: begin
          if (frame_valid && frame_ready) begin
            frame_reg   <= frame_data;
            row         <= '0;
            col         <= '0;
            frame_ready <= 1'b0;
            busy        <= 1'b1;
            state       <= S_SET_ADDR;
          end
        end
        S_SET_ADDR: begin
          if (!pending) begin
            start     <= 1'b1;
            pending   <= 1'b1;
            tx_byte   <= CMD_SET_DDRAM | row_base(2'(row), 8'(COLS));
            tx_rs     <= 1'b0;
            tx_single <= 1'b0;
            tx_long   <= 1'b0;
          end else if (tx_done) begin
            pending <= 1'b0;
            state   <= S_WRITE_CHAR;
          end
        end
        S_WRITE_CHAR: begin
          if (!pending) begin
            start     <= 1'b1;
            pending   <= 1'b1;
            tx_byte   <= frame_reg[FRAME_W-1 -: 8];
            tx_rs     <= 1'b1;
            tx_single <= 1'b0;
            tx_long   <= 1'b0;
          end else if (tx_done) begin
            pending   <= 1'b0;
            frame_reg <= frame_reg << 8;
            if (col != COL_W'(COLS - 1)) begin
              col <= col + COL_W'(1);
            end else if (row != ROW_W'(ROWS - 1)) begin
              row   <= row + ROW_W'(1);
              col   <= '0;
              state <= S_SET_ADDR;
            end else begin
              state       <= S_IDLE;
              frame_ready <= 1'b1;
              busy        <= 1'b0;
            end
          end
        end
        default: state <= S_PWR_WAIT;
      endcase
    end
  end

  lcd_nibble_tx #(
    .T_E  (T_E),
    .T_NIB(T_NIB),
    .T_CMD(T_CMD),
    .T_CLR(T_CLR)
  ) u_nibble_tx (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .tx_byte      (tx_byte),
    .rs           (tx_rs),
    .single_nibble(tx_single),
    .long_wait    (tx_long),
    .done         (tx_done),
    .lcd_e        (lcd_e),
    .lcd_rs       (lcd_rs),
    .lcd_data     (lcd_data)
  );

endmodule

// File: tb/tb_lcd_text_driver.sv
// Scoreboard bench: expected {rs,nibble} stream queued per DUT, checked on each lcd_e fall.
module tb_lcd_text_driver;

  localparam int unsigned TP = 100, TE = 2, TN = 4, TC = 10, TL = 30;
  localparam int CLK_P = 10;

  logic clk = 1'b0;
  always #(CLK_P/2) clk = ~clk;

  logic         reset0 = 1'b1, reset1 = 1'b1;
  logic [255:0] frame_data0 = '0;
  logic [639:0] frame_data1 = '0;
  logic         frame_valid0 = 1'b0, frame_valid1 = 1'b0;
  logic         frame_ready0, busy0, lcd_rs0, lcd_w0, lcd_e0;
  logic         frame_ready1, busy1, lcd_rs1, lcd_w1, lcd_e1;
  logic [3:0]   lcd_data0, lcd_data1;

  lcd_text_driver #(.ROWS(2), .COLS(16), .T_PWRUP(TP), .T_E(TE), .T_NIB(TN), .T_CMD(TC), .T_CLR(TL)) dut0 (
    .clk(clk), .reset(reset0), .frame_data(frame_data0), .frame_valid(frame_valid0),
    .frame_ready(frame_ready0), .busy(busy0), .lcd_rs(lcd_rs0), .lcd_w(lcd_w0),
    .lcd_e(lcd_e0), .lcd_data(lcd_data0));

  lcd_text_driver #(.ROWS(4), .COLS(20), .T_PWRUP(TP), .T_E(TE), .T_NIB(TN), .T_CMD(TC), .T_CLR(TL)) dut1 (
    .clk(clk), .reset(reset1), .frame_data(frame_data1), .frame_valid(frame_valid1),
    .frame_ready(frame_ready1), .busy(busy1), .lcd_rs(lcd_rs1), .lcd_w(lcd_w1),
    .lcd_e(lcd_e1), .lcd_data(lcd_data1));

  int tests = 0, fails = 0;
  logic [4:0] q0[$], q1[$];
  time t_rel0, t_rise0;
  logic want_rise0 = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitors: compare each strobed nibble with the head of the scoreboard.
  always @(negedge lcd_e0) if (!reset0) begin
    tests++;
    assert (q0.size() > 0) else begin
      fails++;
      $error("FAIL d0_extra_nibble observed=%0h expected=none", {lcd_rs0, lcd_data0});
    end
    if (q0.size() > 0) check("d0_nibble", 32'({lcd_rs0, lcd_data0}), 32'(q0.pop_front()));
  end

  always @(negedge lcd_e1) if (!reset1) begin
    tests++;
    assert (q1.size() > 0) else begin
      fails++;
      $error("FAIL d1_extra_nibble observed=%0h expected=none", {lcd_rs1, lcd_data1});
    end
    if (q1.size() > 0) check("d1_nibble", 32'({lcd_rs1, lcd_data1}), 32'(q1.pop_front()));
  end

  always @(posedge lcd_e0) if (want_rise0) begin
    t_rise0    = $time;
    want_rise0 = 1'b0;
  end

  task automatic push(input int sel, input logic [4:0] v);
    if (sel == 0) q0.push_back(v); else q1.push_back(v);
  endtask

  task automatic push_byte(input int sel, input logic rs, input logic [7:0] b);
    push(sel, {rs, b[7:4]});
    push(sel, {rs, b[3:0]});
  endtask

  task automatic push_init(input int sel);
    push(sel, 5'h03); push(sel, 5'h03); push(sel, 5'h03); push(sel, 5'h02);
    push_byte(sel, 1'b0, 8'h28); push_byte(sel, 1'b0, 8'h06);
    push_byte(sel, 1'b0, 8'h0C); push_byte(sel, 1'b0, 8'h01);
  endtask

  function automatic logic [7:0] exp_base(input int r, input int cols);
    case (r)
      0: return 8'h00;
      1: return 8'h40;
      2: return 8'(cols);
      default: return 8'(8'h40 + cols);
    endcase
  endfunction

  task automatic push_frame(input int sel, input int rows, input int cols, input logic [639:0] d);
    for (int r = 0; r < rows; r++) begin
      push_byte(sel, 1'b0, 8'h80 | exp_base(r, cols));
      for (int c = 0; c < cols; c++)
        push_byte(sel, 1'b1, d[(rows*cols-1-(r*cols+c))*8 +: 8]);
    end
  endtask

  // Waits for the expected stream to drain, optionally scrambling DUT0 frame_data each cycle.
  task automatic wait_drain(input int sel, input int budget, input bit scramble);
    int n = 0;
    while (((sel == 0) ? q0.size() : q1.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
      if (scramble) for (int i = 0; i < 8; i++) frame_data0[i*32 +: 32] = $urandom;
    end
    tests++;
    assert (n < budget) else begin
      fails++;
      $error("FAIL drain%0d_timeout observed=%0d expected=<%0d left=%0d", sel, n, budget,
             (sel == 0) ? q0.size() : q1.size());
    end
  endtask

  task automatic wait_ready(input int sel, input int budget);
    int n = 0;
    while (((sel == 0) ? frame_ready0 : frame_ready1) !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("ready%0d", sel), 32'((sel == 0) ? frame_ready0 : frame_ready1), 32'd1);
    check($sformatf("busy%0d_idle", sel), 32'((sel == 0) ? busy0 : busy1), 32'd0);
  endtask

  task automatic reset_dut0();
    reset0 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_e", 32'(lcd_e0), 32'd0);
    check("rst_ready", 32'(frame_ready0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd1);
    check("rst_w", 32'(lcd_w0), 32'd0);
    check("rst_data", 32'({lcd_rs0, lcd_data0}), 32'd0);
    want_rise0 = 1'b1;
    t_rel0     = $time;
    reset0     = 1'b0;
  endtask

  task automatic check_pwrup();
    check("pwrup_delay_ok", 32'((t_rise0 - t_rel0) >= time'((TP + TE) * CLK_P - CLK_P/2)), 32'd1);
  endtask

  logic [127:0] row_a, row_b;
  logic [255:0] snap;
  logic [639:0] big;
  int n;

  initial begin
    row_a = " WELCOME TO CSE ";
    row_b = " I I I  KANPUR  ";

    // Reset then init stream, then idle.
    push_init(0);
    reset_dut0();
    wait_drain(0, 2000, 1'b0);
    check_pwrup();
    wait_ready(0, 200);

    // 2x16 text frame, with frame_data scrambled after acceptance.
    frame_data0 = {row_a, row_b};
    push_frame(0, 2, 16, 640'(frame_data0));
    frame_valid0 = 1'b1;
    @(negedge clk);
    frame_valid0 = 1'b0;
    check("accept_ready_drop", 32'(frame_ready0), 32'd0);
    check("accept_busy", 32'(busy0), 32'd1);
    wait_drain(0, 3000, 1'b1);
    wait_ready(0, 200);

    // frame_valid held through reset and init: accepted on the first IDLE cycle.
    for (int i = 0; i < 8; i++) snap[i*32 +: 32] = $urandom;
    frame_data0  = snap;
    frame_valid0 = 1'b1;
    push_init(0);
    push_frame(0, 2, 16, 640'(snap));
    reset_dut0();
    n = 0;
    while (frame_ready0 !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
      check("held_busy", 32'(busy0 | frame_ready0), 32'd1);
    end
    check("held_first_ready", 32'(frame_ready0), 32'd1);
    check("held_init_done", 32'(q0.size()), 32'd68);
    @(negedge clk);
    frame_valid0 = 1'b0;
    check("held_ready_drop", 32'(frame_ready0), 32'd0);
    wait_drain(0, 3000, 1'b1);
    check_pwrup();
    wait_ready(0, 200);

    // Reset mid-frame after the address and five data bytes.
    frame_data0 = {row_b, row_a};
    push_frame(0, 2, 16, 640'(frame_data0));
    frame_valid0 = 1'b1;
    @(negedge clk);
    frame_valid0 = 1'b0;
    n = 0;
    while (q0.size() > 68 - 12 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("mid_five_bytes", 32'(q0.size()), 32'd56);
    reset0 = 1'b1;
    @(negedge clk);
    check("mid_rst_e", 32'(lcd_e0), 32'd0);
    check("mid_rst_ready", 32'(frame_ready0), 32'd0);
    check("mid_rst_busy", 32'(busy0), 32'd1);
    q0.delete();
    push_init(0);
    reset_dut0();
    wait_drain(0, 2000, 1'b0);
    check_pwrup();
    wait_ready(0, 200);

    // 4x20 frame on the second instance.
    for (int i = 0; i < 80; i++) big[(79-i)*8 +: 8] = 8'(8'h41 + (i % 26));
    frame_data1 = big;
    push_init(1);
    reset1 = 1'b1;
    repeat (2) @(negedge clk);
    reset1 = 1'b0;
    wait_drain(1, 2000, 1'b0);
    wait_ready(1, 200);
    push_frame(1, 4, 20, big);
    frame_valid1 = 1'b1;
    @(negedge clk);
    frame_valid1 = 1'b0;
    check("d1_accept_drop", 32'(frame_ready1), 32'd0);
    wait_drain(1, 6000, 1'b0);
    wait_ready(1, 200);
    check("d1_w", 32'(lcd_w1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
